// File: rtl/mv_mul.sv
// -----------------------------------------------------------------------------
// mv_mul -- fixed-size matrix-vector multiplier working on an external RAM.
//
// After reset is released the block walks the N x N matrix A (row-major at
// MAT_BASE) and the vector x (at VEC_BASE). It computes y = A*x with 32-bit
// wrapping arithmetic and writes y back to OUT_BASE. Once the last (delayed)
// write has landed in RAM it raises valid, which then stays high until reset.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   valid          sticky "results committed" flag
//   raddr_0/ren_0  read port 0, fetches A[i][j]
//   rdata_0        read data port 0 (one-cycle registered latency)
//   raddr_1/ren_1  read port 1, fetches x[j]
//   rdata_1        read data port 1 (one-cycle registered latency)
//   waddr_0/wdata_0/wen_0
//                  write port; the RAM commits one cycle after wen_0
//   rdata_store_0  reserved, constant 0
// -----------------------------------------------------------------------------
module mv_mul #(
  parameter int N        = 3,
  parameter int MAT_BASE = 0,
  parameter int VEC_BASE = 9,
  parameter int OUT_BASE = 12
) (
  input  logic        clk,
  input  logic        rst,
  output logic        valid,
  output logic [31:0] raddr_0,
  output logic        ren_0,
  input  logic [31:0] rdata_0,
  output logic [31:0] raddr_1,
  output logic        ren_1,
  input  logic [31:0] rdata_1,
  output logic [31:0] waddr_0,
  output logic [31:0] wdata_0,
  output logic        wen_0,
  output logic [31:0] rdata_store_0
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_ISSUE = 3'd0,
    S_ACC   = 3'd1,
    S_WRITE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [IW-1:0]   i_reg;
  logic [IW-1:0]   j_reg;
  logic [31:0]     acc_reg;
  logic            drain_cnt_reg;

  logic            last_col;
  logic            last_row;
  logic [31:0]     mat_addr;
  logic [31:0]     vec_addr;
  logic [31:0]     out_addr;

  assign last_col = (j_reg == IW'(N - 1));
  assign last_row = (i_reg == IW'(N - 1));

  assign mat_addr = 32'(MAT_BASE) + 32'(i_reg) * 32'(N) + 32'(j_reg);
  assign vec_addr = 32'(VEC_BASE) + 32'(j_reg);
  assign out_addr = 32'(OUT_BASE) + 32'(i_reg);

  assign rdata_store_0 = '0;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_ISSUE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: indices, accumulator, drain counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_reg         <= '0;
      j_reg         <= '0;
      acc_reg       <= '0;
      drain_cnt_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_ACC: begin
          // Product and sum both truncate to 32 bits (modulo 2^32).
          acc_reg <= acc_reg + rdata_0 * rdata_1;
          if (!last_col) begin
            j_reg <= j_reg + IW'(1);
          end
        end
        S_WRITE: begin
          acc_reg       <= '0;
          j_reg         <= '0;
          drain_cnt_reg <= 1'b0;
          if (!last_row) begin
            i_reg <= i_reg + IW'(1);
          end
        end
        S_DRAIN: begin
          drain_cnt_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_ISSUE: state_next = S_ACC;
      S_ACC:   state_next = last_col ? S_WRITE : S_ISSUE;
      S_WRITE: state_next = last_row ? S_DRAIN : S_ISSUE;
      // Two drain cycles give the RAM's delayed write stage time to commit
      // the final result before valid is raised.
      S_DRAIN: state_next = drain_cnt_reg ? S_DONE : S_DRAIN;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_ISSUE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // The state register resets to ISSUE, which would otherwise assert the read
  // enables while reset is held. Qualifying every output with rst forces the
  // whole output bundle to 0 immediately when reset asserts.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid   = 1'b0;
    ren_0   = 1'b0;
    ren_1   = 1'b0;
    wen_0   = 1'b0;
    raddr_0 = '0;
    raddr_1 = '0;
    waddr_0 = '0;
    wdata_0 = '0;
    if (rst) begin
      raddr_0 = mat_addr;
      raddr_1 = vec_addr;
      waddr_0 = out_addr;
      wdata_0 = acc_reg;
      case (state_reg)
        S_ISSUE: begin
          ren_0 = 1'b1;
          ren_1 = 1'b1;
        end
        S_WRITE: wen_0 = 1'b1;
        S_DONE:  valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_mul.sv
// -----------------------------------------------------------------------------
// tb_mv_mul -- self-checking bench for mv_mul.
// A behavioural RAM (registered reads, one-cycle delayed writes) sits beside
// the DUT. For each case the expected writes are computed with plain loops
// and queued; an independent monitor pops and compares on every wen_0 pulse
// and also watches protocol rules every cycle.
// -----------------------------------------------------------------------------
module tb_mv_mul;

  localparam int N        = 3;
  localparam int MAT_BASE = 0;
  localparam int VEC_BASE = 9;
  localparam int OUT_BASE = 12;
  localparam int MAX_LAT  = 40;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] raddr_0;
  logic        ren_0;
  logic [31:0] rdata_0;
  logic [31:0] raddr_1;
  logic        ren_1;
  logic [31:0] rdata_1;
  logic [31:0] waddr_0;
  logic [31:0] wdata_0;
  logic        wen_0;
  logic [31:0] rdata_store_0;

  mv_mul #(
    .N        (N),
    .MAT_BASE (MAT_BASE),
    .VEC_BASE (VEC_BASE),
    .OUT_BASE (OUT_BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid         (valid),
    .raddr_0       (raddr_0),
    .ren_0         (ren_0),
    .rdata_0       (rdata_0),
    .raddr_1       (raddr_1),
    .ren_1         (ren_1),
    .rdata_1       (rdata_1),
    .waddr_0       (waddr_0),
    .wdata_0       (wdata_0),
    .wen_0         (wen_0),
    .rdata_store_0 (rdata_store_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] mem      [0:15];
  logic [31:0] init_mem [0:15];
  logic        load_req;
  logic        wen_d;
  logic [31:0] waddr_d;
  logic [31:0] wdata_d;

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 16; k++) mem[k] <= init_mem[k];
    end
    if (ren_0) rdata_0 <= mem[raddr_0[3:0]];
    if (ren_1) rdata_1 <= mem[raddr_1[3:0]];
    wen_d   <= wen_0;
    waddr_d <= waddr_0;
    wdata_d <= wdata_0;
    if (wen_d && !load_req) mem[waddr_d[3:0]] <= wdata_d;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] y_ref [0:N-1];
  int          n_vec;
  int          n_fail;
  int          n_wen;
  logic        prev_ren;
  logic        prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: y[i] = sum_j A[i][j]*x[j], everything mod 2^32.
  task automatic compute_ref();
    logic [31:0] s;
    logic [31:0] p;
    for (int r = 0; r < N; r++) begin
      s = 32'd0;
      for (int c = 0; c < N; c++) begin
        p = init_mem[MAT_BASE + r*N + c] * init_mem[VEC_BASE + c];
        s = s + p;
      end
      y_ref[r] = s;
    end
  endtask

  task automatic push_expected();
    wr_t w;
    exp_q.delete();
    n_wen = 0;
    compute_ref();
    for (int r = 0; r < N; r++) begin
      w.addr = 32'(OUT_BASE + r);
      w.data = y_ref[r];
      exp_q.push_back(w);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (rdata_store_0 !== 32'd0) check("rdata_store_0", rdata_store_0, 32'd0);
    if (rst) begin
      if (ren_0 !== ren_1) check("ren_pair", {31'd0, ren_1}, {31'd0, ren_0});
      if (ren_0 && prev_ren) check("ren_then_acc", 32'd1, 32'd0);
      if (ren_0 && (raddr_0 < MAT_BASE || raddr_0 >= MAT_BASE + N*N))
        check("raddr_0_range", raddr_0, 32'(MAT_BASE));
      if (ren_1 && (raddr_1 < VEC_BASE || raddr_1 >= VEC_BASE + N))
        check("raddr_1_range", raddr_1, 32'(VEC_BASE));
      if (prev_valid && !valid) check("valid_sticky", 32'd0, 32'd1);
      if (wen_0) begin
        n_wen++;
        if (valid) check("wen_after_valid", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", waddr_0, 32'hFFFFFFFF);
        end else begin
          w = exp_q.pop_front();
          check("waddr", waddr_0, w.addr);
          check("wdata", wdata_0, w.data);
        end
      end
      prev_ren   = ren_0;
      prev_valid = valid;
    end else begin
      prev_ren   = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},   {31'd0, valid}, 32'd0);
    check({tag, "_ren"},     {30'd0, ren_0, ren_1}, 32'd0);
    check({tag, "_wen"},     {31'd0, wen_0}, 32'd0);
    check({tag, "_raddr_0"}, raddr_0, 32'd0);
    check({tag, "_raddr_1"}, raddr_1, 32'd0);
    check({tag, "_waddr_0"}, waddr_0, 32'd0);
    check({tag, "_wdata_0"}, wdata_0, 32'd0);
  endtask

  task automatic run_case(input string name, input int reset_after);
    int cyc;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 12; k < 16; k++) init_mem[k] = 32'hDEADBEEF;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    push_expected();
    #1;
    check_outputs_zero({name, "_rst"});
    @(negedge clk);
    rst = 1'b1;
    if (reset_after > 0) begin
      repeat (reset_after) @(negedge clk);
      rst = 1'b0;
      #1;
      check_outputs_zero({name, "_midrst"});
      push_expected();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
    end
    cyc = 0;
    while (!valid && cyc < MAX_LAT) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_valid_in_time"}, {31'd0, valid}, 32'd1);
    // When valid first rises, every result must already be in RAM.
    check({name, "_all_writes_seen"}, 32'(exp_q.size()), 32'd0);
    check({name, "_wen_count"}, 32'(n_wen), 32'(N));
    for (int r = 0; r < N; r++)
      check($sformatf("%s_y%0d", name, r), mem[OUT_BASE + r], y_ref[r]);
    repeat (75) @(negedge clk);
    check({name, "_valid_hold"}, {31'd0, valid}, 32'd1);
    check({name, "_wen_count_hold"}, 32'(n_wen), 32'(N));
    $display("case %s: y = %0h %0h %0h", name, y_ref[0], y_ref[1], y_ref[2]);
  endtask

  task automatic set_main();
    int v [0:11] = '{6,1,2,3,7,5,5,2,9,9,3,7};
    for (int k = 0; k < 12; k++) init_mem[k] = 32'(v[k]);
  endtask

  initial begin
    n_vec      = 0;
    n_fail     = 0;
    n_wen      = 0;
    prev_ren   = 1'b0;
    prev_valid = 1'b0;
    load_req   = 1'b0;
    rst        = 1'b0;
    for (int k = 0; k < 16; k++) init_mem[k] = 32'd0;
    #1;
    check_outputs_zero("por");

    // Main vector with hand-derived results.
    set_main();
    run_case("main", 0);
    check("main_hand_y0", mem[12], 32'd71);
    check("main_hand_y1", mem[13], 32'd83);
    check("main_hand_y2", mem[14], 32'd114);

    // Identity matrix.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        init_mem[MAT_BASE + r*N + c] = (r == c) ? 32'd1 : 32'd0;
    init_mem[9] = 32'd4; init_mem[10] = 32'd5; init_mem[11] = 32'd6;
    run_case("identity", 0);

    // Zero vector, random matrix.
    for (int k = 0; k < 9; k++) init_mem[k] = $urandom;
    for (int k = 9; k < 12; k++) init_mem[k] = 32'd0;
    run_case("zero_vec", 0);

    // Wrap-around.
    for (int k = 0; k < 12; k++) init_mem[k] = 32'd0;
    init_mem[0] = 32'hFFFFFFFF;
    init_mem[9] = 32'd2;
    run_case("wrap", 0);
    check("wrap_hand_y0", mem[12], 32'hFFFFFFFE);

    // Reset mid-run with the main vector.
    set_main();
    run_case("midrst", 10);
    check("midrst_hand_y0", mem[12], 32'd71);
    check("midrst_hand_y2", mem[14], 32'd114);

    // Randomized matrices: mix of small and full-width values.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 12; k++)
        init_mem[k] = (t % 2 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      run_case($sformatf("rand%0d", t), (t == 3) ? int'($urandom_range(1, 20)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mv_mul.md
Name: mv_mul

Overview:
- Fixed-size matrix-vector multiplier that works directly on an external dual-read / single-write synchronous RAM.
- After reset is released it reads an N x N matrix (row-major) and an N-element vector, then computes y = A·x.
- It writes the N results back into the same RAM and raises valid.
- Sits beside the RAM wrapper, whose write path is delayed one cycle by a `delay` register stage.

Parameters:
- N, 3, matrix dimension / vector length
- MAT_BASE, 0, word address of A[0][0]; A[i][j] is at MAT_BASE + i*N + j
- VEC_BASE, 9, word address of x[0]; x[j] is at VEC_BASE + j
- OUT_BASE, 12, word address of y[0]; y[i] is at OUT_BASE + i

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- valid  out  1  computation complete; results are committed in RAM
- raddr_0  out  32  read address, port 0 (matrix element)
- ren_0  out  1  read enable, port 0
- rdata_0  in  32  read data, port 0; registered, valid the cycle after the address is presented
- raddr_1  out  32  read address, port 1 (vector element)
- ren_1  out  1  read enable, port 1
- rdata_1  in  32  read data, port 1; same 1-cycle latency
- waddr_0  out  32  write address
- wdata_0  out  32  write data
- wen_0  out  1  write enable; RAM commits the write one cycle later (delayed write path)
- rdata_store_0  out  32  reserved; tied to 0

Behaviour:
- Reset value of every output while rst=0: 0. Internal state is cleared: row index i=0, column index j=0, accumulator=0, state=ISSUE.
- State ISSUE:
  - drive raddr_0 = MAT_BASE+i*N+j and raddr_1 = VEC_BASE+j
  - ren_0 = ren_1 = 1
  - next state: ACC
- State ACC (rdata_0/rdata_1 now hold A[i][j] and x[j]):
  - acc <= acc + rdata_0*rdata_1
  - if j < N-1: j <= j+1, next state ISSUE
  - otherwise next state WRITE
  - ren_0 = ren_1 = 0
- State WRITE:
  - one-cycle pulse wen_0=1, waddr_0 = OUT_BASE+i, wdata_0 = final accumulator
  - acc <= 0, j <= 0
  - if i < N-1: i <= i+1, next state ISSUE
  - otherwise next state DRAIN
- State DRAIN:
  - wait 2 cycles so the delayed final write lands in RAM
  - next state DONE
- State DONE:
  - valid = 1
  - no further reads or writes
  - remain in DONE until rst is asserted
- Arithmetic: 32-bit unsigned. The product keeps its low 32 bits; the accumulator wraps modulo 2^32.
- Outputs when idle: wen_0, ren_0, ren_1 are 0 in every state other than the one that asserts them. Address and data outputs may hold their last value.
- Latency with N=3: 3 rows × (2N+1) = 21 cycles, plus 2 drain cycles. valid must be 1 no later than 40 cycles after rst deasserts.
- valid is a sticky level, never a pulse.
- Reset mid-operation: asserting rst at any cycle immediately (asynchronously) forces valid=0, wen_0=0, ren_*=0 and restarts the computation from i=j=0 when released. Partially written outputs may remain in RAM.
- The block never reads or writes addresses outside the three parameterised regions.

Test Plan:
- Main vector: RAM[0..11] = 6,1,2,3,7,5,5,2,9,9,3,7; release rst; wait 99 cycles -> valid=1 and stays 1; RAM[12]=71, RAM[13]=83, RAM[14]=114.
- Identity matrix: A = I, x = (4,5,6) -> RAM[12..14] = 4,5,6; valid within 40 cycles.
- Zero vector: any A, x = 0 -> RAM[12..14] = 0,0,0; exactly 3 wen_0 pulses, addresses 12, 13, 14 in order.
- Wrap-around: A[0][*] = 0xFFFFFFFF,0,0; x[0] = 2 -> y[0] = 0xFFFFFFFE (mod 2^32).
- Reset mid-run: assert rst 10 cycles after release -> outputs 0 immediately; re-release -> correct results as in the main vector; valid low until completion.
- Protocol check: every ren_* cycle is followed by exactly one ACC cycle; wen_0 is never asserted after valid rises; rdata_store_0 is always 0.
